// File: rtl/wave_frame_pack_pkg.sv
// -----------------------------------------------------------------------------
// wave_frame_pack_pkg
//   Shared definitions for the waveform frame packer:
//     AXIS_DW   - AXI4-Stream data width (32)
//     OVF_MAX   - saturation value of the dropped-sample counter
//     state_t   - packer FSM encoding (IDLE=0, RUN=1, PAD=2)
//     sat_inc16 - saturating 16-bit increment used by the overflow counter
// -----------------------------------------------------------------------------
package wave_frame_pack_pkg;

   localparam int          AXIS_DW = 32;
   localparam logic [15:0] OVF_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PAD  = 2'd2
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == OVF_MAX) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/wave_frame_pack_if.sv
// -----------------------------------------------------------------------------
// wave_frame_pack_if
//   AXI4-Stream bundle between the frame packer and the conversion stage.
//   Signals:
//     tvalid  - word valid (source -> sink)
//     tdata   - word data, DW bits (source -> sink)
//     tlast   - final word of frame (source -> sink)
//     tready  - sink ready (sink -> source)
//   Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface wave_frame_pack_if
   import wave_frame_pack_pkg::*;
#(
   parameter int DW = AXIS_DW
);
   logic          tvalid;
   logic [DW-1:0] tdata;
   logic          tlast;
   logic          tready;

   modport master (output tvalid, output tdata, output tlast, input  tready);
   modport slave  (input  tvalid, input  tdata, input  tlast, output tready);

endinterface

// File: rtl/wave_frame_pack_sfifo.sv
// -----------------------------------------------------------------------------
// wave_sfifo
//   Synchronous FIFO, depth 2**AW words of DW bits, with a registered
//   occupancy count driving the full/empty flags and a synchronous clear.
//   Ports:
//     clk      - clock
//     rst_n    - asynchronous active-low reset (pointers and count only)
//     clr      - synchronous clear, empties the FIFO
//     wr_en    - write request (ignored while full)
//     wr_data  - write data
//     rd_en    - read request (ignored while empty), pops the head word
//     rd_data  - head word, valid whenever !empty
//     full     - count == depth
//     empty    - count == 0
//   The head word is presented combinationally: the consumer registers it
//   in its own output stage, which keeps sample-to-tvalid latency at two
//   clocks.
// -----------------------------------------------------------------------------
module wave_sfifo #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty
);

   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          wr_ok;
   logic          rd_ok;

   // Flags come from the registered count only, so a write on a full FIFO
   // is refused even when a read frees a slot in the same cycle.
   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign wr_ok   = wr_en & ~full & ~clr;
   assign rd_ok   = rd_en & ~empty & ~clr;
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/wave_frame_pack.sv
// -----------------------------------------------------------------------------
// wave_frame_pack
//   Packs a raw 32-bit sample stream into AXI4-Stream frames of programmable
//   length (tlast on the final word), buffering samples in a 16-word FIFO.
//   Ports:
//     axis_clk   - single clock
//     rst_n      - asynchronous active-low reset
//     frame_en   - level, 1 = accept samples and build frames
//     frame_len  - words per frame, sampled at frame start, 0 treated as 1
//     smp_valid  - sample strobe (no backpressure to the source)
//     smp_data   - sample word
//     axis       - AXIS master (tvalid/tdata/tlast out, tready in)
//     busy       - FSM not in IDLE
//     ovf_cnt    - dropped-sample count, saturating
//     frame_cnt  - completed-frame count, wrapping
//   A frame cut short by frame_en falling is completed in PAD: stored
//   samples go first, then zero words up to the latched length.
// -----------------------------------------------------------------------------
module wave_frame_pack
   import wave_frame_pack_pkg::*;
#(
   parameter int FIFO_AW = 4,
   parameter int LEN_W   = 12
) (
   input  logic               axis_clk,
   input  logic               rst_n,
   input  logic               frame_en,
   input  logic [LEN_W-1:0]   frame_len,
   input  logic               smp_valid,
   input  logic [AXIS_DW-1:0] smp_data,
   wave_frame_pack_if.master  axis,
   output logic               busy,
   output logic [15:0]        ovf_cnt,
   output logic [15:0]        frame_cnt
);

   state_t               state_reg;
   logic [LEN_W-1:0]     len_reg;
   logic [LEN_W-1:0]     word_cnt_reg;
   logic                 tvalid_reg;
   logic [AXIS_DW-1:0]   tdata_reg;
   logic                 tlast_reg;
   logic [15:0]          ovf_reg;
   logic [15:0]          frame_reg;

   logic                 hs;
   logic                 end_hs;
   logic                 out_free;
   logic                 pad_abort;
   logic                 load;
   logic                 load_last;
   logic [AXIS_DW-1:0]   load_data;
   logic [LEN_W-1:0]     start_len;
   logic [LEN_W-1:0]     word_cnt_next;
   logic [LEN_W-1:0]     len_next;
   logic                 smp_drop;

   logic                 fifo_clr;
   logic                 fifo_wr;
   logic                 fifo_rd;
   logic [AXIS_DW-1:0]   fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;

   wave_sfifo #(
      .AW (FIFO_AW),
      .DW (AXIS_DW)
   ) u_fifo (
      .clk     (axis_clk),
      .rst_n   (rst_n),
      .clr     (fifo_clr),
      .wr_en   (fifo_wr),
      .wr_data (smp_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      hs        = tvalid_reg & axis.tready;
      end_hs    = hs & tlast_reg;
      out_free  = ~tvalid_reg | axis.tready;
      start_len = (frame_len == '0) ? LEN_W'(1) : frame_len;
      // PAD entered with nothing sent and nothing stored: there is no
      // frame to complete, so return to IDLE silently.
      pad_abort = fifo_empty & ~tvalid_reg & (word_cnt_reg == '0);

      fifo_wr   = smp_valid & frame_en & (state_reg != ST_PAD) & ~fifo_full;
      smp_drop  = smp_valid & frame_en & fifo_full;
      // Clearing only while frame_en is low keeps the sample that arrives
      // on the IDLE->RUN cycle.
      fifo_clr  = (state_reg == ST_IDLE) & ~frame_en;

      load = 1'b0;
      case (state_reg)
         // A final handshake with frame_en low heads to IDLE; nothing more
         // may be loaded into the output register.
         ST_RUN:  load = out_free & ~fifo_empty & ~(end_hs & ~frame_en);
         ST_PAD:  load = out_free & ~end_hs & ~pad_abort;
         default: load = 1'b0;
      endcase
      fifo_rd   = load & ~fifo_empty;
      load_data = fifo_empty ? '0 : fifo_rdata;

      // The register holds at most one word, so a newly loaded word's
      // index is the handshake count after this edge, checked against the
      // length in force after this edge (re-latched on a frame boundary).
      if (end_hs) begin
         word_cnt_next = '0;
      end else if (hs) begin
         word_cnt_next = word_cnt_reg + LEN_W'(1);
      end else begin
         word_cnt_next = word_cnt_reg;
      end
      len_next  = ((state_reg == ST_RUN) & end_hs & frame_en) ? start_len : len_reg;
      load_last = (word_cnt_next == len_next - LEN_W'(1));
   end

   always_ff @(posedge axis_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         len_reg      <= LEN_W'(1);
         word_cnt_reg <= '0;
         tvalid_reg   <= 1'b0;
         tdata_reg    <= '0;
         tlast_reg    <= 1'b0;
         ovf_reg      <= '0;
         frame_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (frame_en) begin
                  state_reg    <= ST_RUN;
                  len_reg      <= start_len;
                  word_cnt_reg <= '0;
               end
            end
            ST_RUN: begin
               word_cnt_reg <= word_cnt_next;
               len_reg      <= len_next;
               if (end_hs) begin
                  frame_reg <= frame_reg + 16'd1;
                  if (!frame_en) begin
                     state_reg <= ST_IDLE;
                  end
               end else if (!frame_en) begin
                  state_reg <= ST_PAD;
               end
            end
            ST_PAD: begin
               word_cnt_reg <= word_cnt_next;
               if (end_hs) begin
                  frame_reg <= frame_reg + 16'd1;
                  state_reg <= ST_IDLE;
               end else if (pad_abort) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase

         // Output register: data/tlast only change on a load, and a load
         // while valid is only possible together with a handshake.
         if (load) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= load_data;
            tlast_reg  <= load_last;
         end else if (hs) begin
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
         end

         if (smp_drop) begin
            ovf_reg <= sat_inc16(ovf_reg);
         end
      end
   end

   assign axis.tvalid = tvalid_reg;
   assign axis.tdata  = tdata_reg;
   assign axis.tlast  = tlast_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign ovf_cnt     = ovf_reg;
   assign frame_cnt   = frame_reg;

endmodule

// File: tb/tb_wave_frame_pack.sv
// -----------------------------------------------------------------------------
// tb_wave_frame_pack
//   Directed bench for wave_frame_pack. Expected output words are derived
//   from the frame rules (chunk accepted samples into frames, zero-pad a
//   truncated frame) into a queue; a compare process checks every AXIS
//   handshake against it and checks stability while stalled.
// -----------------------------------------------------------------------------
module tb_wave_frame_pack;
   import wave_frame_pack_pkg::*;

   logic        axis_clk = 1'b0;
   logic        rst_n;
   logic        frame_en;
   logic [11:0] frame_len;
   logic        smp_valid;
   logic [31:0] smp_data;
   logic        busy;
   logic [15:0] ovf_cnt;
   logic [15:0] frame_cnt;

   wave_frame_pack_if #(.DW(32)) axis_if ();

   wave_frame_pack #(
      .FIFO_AW (4),
      .LEN_W   (12)
   ) dut (
      .axis_clk  (axis_clk),
      .rst_n     (rst_n),
      .frame_en  (frame_en),
      .frame_len (frame_len),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .axis      (axis_if),
      .busy      (busy),
      .ovf_cnt   (ovf_cnt),
      .frame_cnt (frame_cnt)
   );

   always #5 axis_clk = ~axis_clk;

   int          total = 0;
   int          bad   = 0;
   logic [32:0] exp_q [$];     // {tlast, tdata}
   logic [31:0] acc_q [$];     // samples the source will have accepted
   int          exp_frames = 0;
   bit          chk_en = 1'b0;
   int          tr_mode = 0;   // 0: tready=1, 1: toggle, 2: tready=0
   bit          stall_prev = 1'b0;
   logic [31:0] prev_d;
   logic        prev_l;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Frame rules: split accepted samples into frames of max(len,1) words,
   // tlast on the last word; a truncated frame is filled with zero words.
   task automatic model_build(input int len, input bit pad);
      int L;
      int idx;
      logic [31:0] d;
      L   = (len == 0) ? 1 : len;
      idx = 0;
      while (acc_q.size() > 0) begin
         d = acc_q.pop_front();
         exp_q.push_back({(idx == L - 1), d});
         if (idx == L - 1) exp_frames++;
         idx = (idx + 1) % L;
      end
      if (pad) begin
         while (idx != 0) begin
            exp_q.push_back({(idx == L - 1), 32'h0});
            if (idx == L - 1) exp_frames++;
            idx = (idx + 1) % L;
         end
      end
   endtask

   task automatic send(input logic [31:0] d);
      @(negedge axis_clk);
      smp_valid = 1'b1;
      smp_data  = d;
   endtask

   task automatic idle_in();
      @(negedge axis_clk);
      smp_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 300; c++) begin
         if (exp_q.size() == 0 && axis_if.tvalid === 1'b0) break;
         @(negedge axis_clk);
      end
      check("drain_pending_words", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic apply_reset();
      chk_en = 1'b0;
      tr_mode = 0;
      @(negedge axis_clk);
      rst_n     = 1'b0;
      frame_en  = 1'b0;
      smp_valid = 1'b0;
      smp_data  = '0;
      frame_len = '0;
      exp_q.delete();
      acc_q.delete();
      exp_frames = 0;
      repeat (2) @(negedge axis_clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
   endtask

   // tready driver
   initial begin
      axis_if.tready = 1'b1;
      forever begin
         @(negedge axis_clk);
         case (tr_mode)
            0:       axis_if.tready = 1'b1;
            1:       axis_if.tready = ~axis_if.tready;
            default: axis_if.tready = 1'b0;
         endcase
      end
   end

   // Compare process: sampled mid-low-phase, where outputs and tready are
   // the values the next rising edge will act on.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge axis_clk);
         #3;
         if (chk_en && rst_n === 1'b1) begin
            if (stall_prev) begin
               check("stall_tvalid", 32'(axis_if.tvalid), 32'd1);
               check("stall_tdata", axis_if.tdata, prev_d);
               check("stall_tlast", 32'(axis_if.tlast), 32'(prev_l));
            end
            if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_word: got 0x%08h expected no word", axis_if.tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("word_tdata", axis_if.tdata, e[31:0]);
                  check("word_tlast", 32'(axis_if.tlast), 32'(e[32]));
               end
            end
            stall_prev = (axis_if.tvalid === 1'b1) && (axis_if.tready === 1'b0);
            prev_d     = axis_if.tdata;
            prev_l     = axis_if.tlast;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      frame_en  = 1'b0;
      frame_len = '0;
      smp_valid = 1'b0;
      smp_data  = '0;
      apply_reset();

      // Reset state
      @(negedge axis_clk);
      check("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
      check("rst_tdata", axis_if.tdata, 32'd0);
      check("rst_tlast", 32'(axis_if.tlast), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // 1: len 4, samples 1..8, tready high
      for (int i = 1; i <= 8; i++) acc_q.push_back(32'(i));
      model_build(4, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge axis_clk);
         if (i == 1) check("t1_latency_c1_tvalid", 32'(axis_if.tvalid), 32'd0);
         if (i == 2) begin
            check("t1_latency_c2_tvalid", 32'(axis_if.tvalid), 32'd1);
            check("t1_latency_c2_tdata", axis_if.tdata, 32'd1);
         end
         frame_len = 12'd4;
         frame_en  = 1'b1;
         smp_valid = 1'b1;
         smp_data  = 32'(i + 1);
      end
      idle_in();
      wait_drain();
      check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
      check("t1_frame_cnt_model", 32'(frame_cnt), 32'(exp_frames));
      check("t1_ovf_cnt", 32'(ovf_cnt), 32'd0);

      // 2: same, tready toggling
      apply_reset();
      tr_mode = 1;
      for (int i = 1; i <= 8; i++) acc_q.push_back(32'h200 + 32'(i));
      model_build(4, 1'b0);
      frame_len = 12'd4;
      frame_en  = 1'b1;
      for (int i = 1; i <= 8; i++) send(32'h200 + 32'(i));
      idle_in();
      wait_drain();
      check("t2_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      check("t2_ovf_cnt", 32'(ovf_cnt), 32'd0);

      // 3: tready low, 20 samples: 16 in FIFO + 1 in output register, 3 dropped
      apply_reset();
      tr_mode = 2;
      @(negedge axis_clk);
      for (int i = 1; i <= 17; i++) acc_q.push_back(32'h300 + 32'(i));
      model_build(17, 1'b0);
      frame_len = 12'd17;
      frame_en  = 1'b1;
      for (int i = 1; i <= 20; i++) send(32'h300 + 32'(i));
      idle_in();
      check("t3_ovf_cnt", 32'(ovf_cnt), 32'd3);
      check("t3_hold_tvalid", 32'(axis_if.tvalid), 32'd1);
      check("t3_hold_tdata", axis_if.tdata, 32'h301);
      tr_mode = 0;
      wait_drain();
      check("t3_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

      // 4: len 6, two samples then frame_en low -> zero padding
      apply_reset();
      acc_q.push_back(32'hA0);
      acc_q.push_back(32'hA1);
      model_build(6, 1'b1);
      frame_len = 12'd6;
      frame_en  = 1'b1;
      send(32'hA0);
      send(32'hA1);
      @(negedge axis_clk);
      smp_valid = 1'b0;
      frame_en  = 1'b0;
      wait_drain();
      repeat (2) @(negedge axis_clk);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t4_ovf_cnt", 32'(ovf_cnt), 32'd0);

      // 5: frame_len 0 -> single-word frames
      apply_reset();
      for (int i = 0; i < 5; i++) acc_q.push_back(32'h700 + 32'(i));
      model_build(0, 1'b0);
      frame_len = 12'd0;
      frame_en  = 1'b1;
      for (int i = 0; i < 5; i++) send(32'h700 + 32'(i));
      idle_in();
      wait_drain();
      frame_en = 1'b0;
      repeat (3) @(negedge axis_clk);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

      // 6: reset mid-frame, then a clean frame
      apply_reset();
      for (int i = 0; i < 3; i++) acc_q.push_back(32'h500 + 32'(i));
      model_build(8, 1'b0);
      frame_len = 12'd8;
      frame_en  = 1'b1;
      for (int i = 0; i < 3; i++) send(32'h500 + 32'(i));
      idle_in();
      repeat (4) @(negedge axis_clk);
      check("t6_pre_busy", 32'(busy), 32'd1);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("t6_rst_tvalid", 32'(axis_if.tvalid), 32'd0);
      check("t6_rst_tdata", axis_if.tdata, 32'd0);
      check("t6_rst_tlast", 32'(axis_if.tlast), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      exp_q.delete();
      acc_q.delete();
      exp_frames = 0;
      frame_en   = 1'b0;
      @(negedge axis_clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      acc_q.push_back(32'h600);
      acc_q.push_back(32'h601);
      model_build(2, 1'b0);
      frame_len = 12'd2;
      frame_en  = 1'b1;
      send(32'h600);
      send(32'h601);
      idle_in();
      wait_drain();
      check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
